// File: rtl/instr_mem_loader_if.sv
// Byte-stream input, instruction-memory write port and CPU status for the loader.
// master is the loader side; slave is the environment driving the stream.
interface instr_mem_loader_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     start;
    logic [7:0]               rx_data;
    logic                     rx_valid;
    logic                     rx_ready;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic                     cpu_rst;
    logic                     done;
    logic                     err;

    modport master (
        input  start, rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err
    );

    modport slave (
        output start, rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Loads a framed, XOR-checksummed little-endian byte stream into instruction memory
// and holds the CPU in reset until a complete, verified program has been written.
module instr_mem_loader #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int unsigned              MAX_WORDS     = 256
) (
    input logic                clk,
    input logic                rst,
    instr_mem_loader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, HDR_LO, HDR_HI, DATA, CHK, DONE, ERROR
    } state_e;

    state_e                   state_q, state_d;
    logic [15:0]              count_q, count_d;
    logic [15:0]              word_idx_q, word_idx_d;
    logic [1:0]               byte_idx_q, byte_idx_d;
    logic [23:0]              asm_q, asm_d;
    logic [7:0]               xor_q, xor_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic                     cpu_rst_q, cpu_rst_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic        rx_ready;
    logic        accept;
    logic        idle_like;
    logic [15:0] cnt_full;
    logic        cnt_bad;
    logic        last_word;

    assign accept    = bus.rx_valid & rx_ready;
    assign idle_like = (state_q == IDLE) || (state_q == DONE) || (state_q == ERROR);
    assign cnt_full  = {bus.rx_data, count_q[7:0]};
    assign cnt_bad   = (cnt_full == 16'd0) || (32'(cnt_full) > MAX_WORDS);
    assign last_word = (word_idx_q == count_q - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERROR: if (bus.start) state_d = HDR_LO;
            HDR_LO:            if (accept) state_d = HDR_HI;
            HDR_HI:            if (accept) state_d = cnt_bad ? ERROR : DATA;
            DATA:              if (accept && byte_idx_q == 2'd3 && last_word) state_d = CHK;
            CHK:               if (accept) state_d = (bus.rx_data == xor_q) ? DONE : ERROR;
            default:           state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_ready = (state_q == HDR_LO) || (state_q == HDR_HI) ||
                   (state_q == DATA)   || (state_q == CHK);
    end

    // The assembly register is separate from mem_wdata, so bytes keep flowing during a write.
    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        count_d     = count_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        xor_d       = xor_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rst_d   = cpu_rst_q;
        done_d      = done_q;
        err_d       = err_q;

        if (idle_like && bus.start) begin
            cpu_rst_d  = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
            xor_d      = 8'd0;
            word_idx_d = 16'd0;
        end

        if (accept) begin
            if (state_q != CHK) xor_d = xor_q ^ bus.rx_data;
            case (state_q)
                HDR_LO: count_d[7:0] = bus.rx_data;
                HDR_HI: begin
                    count_d[15:8] = bus.rx_data;
                    byte_idx_d    = 2'd0;
                end
                DATA: begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0:    asm_d[7:0]   = bus.rx_data;
                        2'd1:    asm_d[15:8]  = bus.rx_data;
                        2'd2:    asm_d[23:16] = bus.rx_data;
                        default: begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = DATA_WIDTH'({bus.rx_data, asm_q});
                            mem_addr_d  = BASE_ADDR + ADDRESS_WIDTH'({word_idx_q, 2'b00});
                            word_idx_d  = word_idx_q + 16'd1;
                        end
                    endcase
                end
                default: ;
            endcase
        end

        if (state_q == CHK && state_d == DONE) begin
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
        end
        if (state_q != ERROR && state_d == ERROR) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            count_q     <= 16'd0;
            word_idx_q  <= 16'd0;
            byte_idx_q  <= 2'd0;
            asm_q       <= 24'd0;
            xor_q       <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            xor_q       <= xor_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.rx_ready  = rx_ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader: a frame-level model queues expected writes
// and final status; a monitor compares every memory write and cycle-level invariant.
module tb_instr_mem_loader;

    localparam int          AW   = 32;
    localparam logic [31:0] BASE = 32'hFFFF_FFF0;
    localparam int          MAXW = 256;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_mem_loader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) bus ();

    instr_mem_loader #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (32),
        .BASE_ADDR    (BASE),
        .MAX_WORDS    (MAXW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: runs just after each rising edge, independent of the stimulus.
    logic [31:0] last_addr = BASE;
    logic [31:0] last_data = 32'd0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check("rst_mem_we",   bus.mem_we,    1'b0);
                check("rst_rx_ready", bus.rx_ready,  1'b0);
                check("rst_cpu_rst",  bus.cpu_rst,   1'b1);
                check("rst_done",     bus.done,      1'b0);
                check("rst_err",      bus.err,       1'b0);
                check("rst_mem_addr", bus.mem_addr,  BASE);
                check("rst_wdata",    bus.mem_wdata, 32'd0);
                last_addr = BASE;
                last_data = 32'd0;
            end else begin
                check("cpu_rst_vs_done", bus.cpu_rst, !bus.done);
                check("done_err_excl",   bus.done & bus.err, 1'b0);
                if (bus.mem_we) begin
                    check("write_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check("wr_addr", bus.mem_addr,  e.addr);
                        check("wr_data", bus.mem_wdata, e.data);
                    end
                    last_addr = bus.mem_addr;
                    last_data = bus.mem_wdata;
                end else begin
                    check("hold_addr",  bus.mem_addr,  last_addr);
                    check("hold_wdata", bus.mem_wdata, last_data);
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        t = 0;
        while (!bus.rx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("rx_ready_wait", t < 100, 1'b1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    // Reference model works on the frame as a whole: header count, words, XOR checksum.
    task automatic run_frame(input bq_t f, input int max_gap, input int limit, input bit start_mid);
        int   n, total, nsend;
        bit   bad_cnt, good;
        logic [7:0] x;
        n       = {f[1], f[0]};
        bad_cnt = (n == 0) || (n > MAXW);
        total   = bad_cnt ? 2 : 4 * n + 3;
        nsend   = (limit >= 0 && limit < total) ? limit : total;
        good    = 1'b0;
        if (!bad_cnt) begin
            x = 8'd0;
            for (int i = 0; i < 4 * n + 2; i++) x ^= f[i];
            good = (f[4 * n + 2] == x);
            for (int w = 0; w < n; w++) begin
                if (2 + 4 * w + 3 < nsend) begin
                    wr_t e;
                    e.addr = BASE + 32'(4 * w);
                    e.data = {f[2+4*w+3], f[2+4*w+2], f[2+4*w+1], f[2+4*w]};
                    exp_q.push_back(e);
                end
            end
        end
        pulse_start();
        for (int i = 0; i < nsend; i++) begin
            if (start_mid && i == 3) pulse_start();
            send_byte(f[i], $urandom_range(max_gap, 0));
        end
        repeat (2) @(negedge clk);
        if (nsend == total) begin
            check("writes_drained", exp_q.size(), 0);
            check("done",           bus.done,     !bad_cnt && good);
            check("err",            bus.err,      !(!bad_cnt && good));
            check("cpu_rst",        bus.cpu_rst,  !(!bad_cnt && good));
            check("rx_ready_end",   bus.rx_ready, 1'b0);
        end
    endtask

    function automatic bq_t gen_frame(input int n, input bit corrupt);
        bq_t        f;
        logic [7:0] x;
        f = {};
        f.push_back(n[7:0]);
        f.push_back(n[15:8]);
        if (n > 0 && n <= MAXW) begin
            for (int i = 0; i < 4 * n; i++) f.push_back(8'($urandom));
            x = 8'd0;
            foreach (f[i]) x ^= f[i];
            f.push_back(corrupt ? (x ^ (8'd1 << $urandom_range(7, 0))) : x);
        end
        return f;
    endfunction

    initial begin
        bq_t f2, f3, fb;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Bytes offered while idle must not be taken.
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        repeat (4) begin
            @(negedge clk);
            check("idle_rx_ready", bus.rx_ready, 1'b0);
        end
        bus.rx_valid = 1'b0;

        f2 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h55};
        run_frame(f2, 0, -1, 1'b0);
        check("good_addr_hold", last_addr, BASE + 32'd4);
        check("good_data_hold", last_data, 32'h1122_3344);

        f3 = f2;
        f3[10] = 8'h54;
        run_frame(f3, 0, -1, 1'b0);

        fb = '{8'h00, 8'h00};
        run_frame(fb, 0, -1, 1'b0);
        fb = '{8'h01, 8'h01};
        run_frame(fb, 0, -1, 1'b0);

        run_frame(f2, 3, -1, 1'b1);

        // Abort after the 6th byte; only the first word may have been written.
        run_frame(f2, 0, 6, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_writes", exp_q.size(), 0);
        check("abort_cpu_rst",   bus.cpu_rst,  1'b1);
        check("abort_done",      bus.done,     1'b0);
        run_frame(f2, 1, -1, 1'b0);

        run_frame(gen_frame(1, 1'b0), 0, -1, 1'b0);
        run_frame(gen_frame(MAXW, 1'b0), 0, -1, 1'b0);
        run_frame(gen_frame(MAXW + 1, 1'b0), 0, -1, 1'b0);

        for (int k = 0; k < 25; k++) begin
            int r, n;
            r = $urandom_range(9, 0);
            if (r == 0) begin
                case ($urandom_range(2, 0))
                    0:       n = 0;
                    1:       n = MAXW + 1 + $urandom_range(200, 0);
                    default: n = 65535;
                endcase
            end else begin
                n = $urandom_range(6, 1);
            end
            run_frame(gen_frame(n, $urandom_range(3, 0) == 0), $urandom_range(3, 0), -1,
                      $urandom_range(1, 0) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
